// File: rtl/pulpino_boot_pkg.sv
// Shared types and default timing constants for the PULPino boot sequencer.
package pulpino_boot_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RELEASE    = 2'd1,
        WAIT_LOAD  = 2'd2,
        RUN        = 2'd3
    } boot_state_e;

    localparam int DEF_POR_CYCLES      = 1024;
    localparam int DEF_FETCH_DLY       = 8;
    localparam int DEF_SPI_IDLE_CYCLES = 4096;
    localparam int DEF_TIMEOUT_CYCLES  = 1 << 20;

    // Counter width large enough to hold any count up to the timeout.
    function automatic int boot_cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles) + 1;
    endfunction

endpackage

// File: rtl/boot_sync.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module boot_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pulpino_boot_seq.sv
// Boot sequencer: drives the SoC reset and fetch enable, optionally parking the core
// until an SPI load finishes (done strobe, bus quiescence or timeout).
module pulpino_boot_seq
    import pulpino_boot_pkg::*;
#(
    parameter int POR_CYCLES      = DEF_POR_CYCLES,
    parameter int FETCH_DLY       = DEF_FETCH_DLY,
    parameter int SPI_IDLE_CYCLES = DEF_SPI_IDLE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boot_mode_i,
    input  logic       spi_cs_i,
    input  logic       loader_done_i,
    input  logic       soft_reset_i,
    output logic       rst_n_o,
    output logic       fetch_enable_o,
    output logic [1:0] state_o,
    output logic       boot_timeout_o
);

    localparam int CNT_W = boot_cnt_width(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] FDLY_LAST = CNT_W'(FETCH_DLY - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(SPI_IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(SPI_IDLE_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    boot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              seen_cs_q, seen_cs_d;
    logic              boot_timeout_q, boot_timeout_d;
    logic              rst_n_q, rst_n_d;
    logic              fetch_en_q, fetch_en_d;
    logic              cs_s;
    logic              idle_exit;
    logic              timeout_hit;

    // CS idles high, so the synchronizer resets to 1 to avoid a phantom CS-low.
    boot_sync #(
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d_i (spi_cs_i),
        .q_o (cs_s)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idle_cnt_d     = idle_cnt_q;
        seen_cs_d      = seen_cs_q;
        boot_timeout_d = boot_timeout_q;
        idle_exit      = 1'b0;
        timeout_hit    = 1'b0;

        case (state_q)
            RESET_HOLD: begin
                if (cnt_q == POR_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == FDLY_LAST) begin
                    state_d = boot_mode_i ? WAIT_LOAD : RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (!cs_s) begin
                    seen_cs_d  = 1'b1;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                idle_exit   = seen_cs_q && cs_s && (idle_cnt_q == IDLE_LAST);
                timeout_hit = (cnt_q == TO_LAST);
                if (loader_done_i || idle_exit || timeout_hit) begin
                    state_d = RUN;
                end
                // The flag records only exits that the timeout alone caused.
                if (timeout_hit && !loader_done_i && !idle_exit) begin
                    boot_timeout_d = 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
                state_d = RESET_HOLD;
            end
        endcase

        if (soft_reset_i) begin
            state_d    = RESET_HOLD;
            cnt_d      = '0;
            idle_cnt_d = '0;
            seen_cs_d  = 1'b0;
        end

        rst_n_d    = (state_d != RESET_HOLD);
        fetch_en_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RESET_HOLD;
            cnt_q          <= '0;
            idle_cnt_q     <= '0;
            seen_cs_q      <= 1'b0;
            boot_timeout_q <= 1'b0;
            rst_n_q        <= 1'b0;
            fetch_en_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            seen_cs_q      <= seen_cs_d;
            boot_timeout_q <= boot_timeout_d;
            rst_n_q        <= rst_n_d;
            fetch_en_q     <= fetch_en_d;
        end
    end

    assign rst_n_o        = rst_n_q;
    assign fetch_enable_o = fetch_en_q;
    assign state_o        = state_q;
    assign boot_timeout_o = boot_timeout_q;

endmodule

// File: tb/tb_pulpino_boot_seq.sv
// Bench for pulpino_boot_seq: phase/elapsed-cycle reference model checked every cycle,
// directed timing cases pinned with literal edge numbers, then randomized traffic.
module tb_pulpino_boot_seq;

    localparam int POR  = 16;
    localparam int FDLY = 4;
    localparam int IDLE = 32;
    localparam int TMO  = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       boot_mode = 1'b0;
    logic       spi_cs = 1'b1;
    logic       loader_done = 1'b0;
    logic       soft_reset = 1'b0;
    logic       rst_n;
    logic       fetch_en;
    logic [1:0] state;
    logic       boot_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulpino_boot_seq #(
        .POR_CYCLES      (POR),
        .FETCH_DLY       (FDLY),
        .SPI_IDLE_CYCLES (IDLE),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .boot_mode_i    (boot_mode),
        .spi_cs_i       (spi_cs),
        .loader_done_i  (loader_done),
        .soft_reset_i   (soft_reset),
        .rst_n_o        (rst_n),
        .fetch_enable_o (fetch_en),
        .state_o        (state),
        .boot_timeout_o (boot_timeout)
    );

    // Reference model: phase 0 hold, 1 release, 2 wait-for-load, 3 run.
    // elapsed = edges spent in the current phase; quiet = consecutive synced-CS-high edges.
    int   m_phase = 0;
    int   m_elapsed = 0;
    int   m_quiet = 0;
    int   edges = 0;
    bit   m_seen = 0;
    bit   m_to = 0;
    bit   m_valid = 0;
    logic cs_p1 = 1'b1;
    logic cs_p2 = 1'b1;

    always @(posedge clk) begin
        logic cs_now;
        bit   seen_before;
        bit   quiet_done;
        cs_now = cs_p2;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_quiet = 0; m_seen = 0; m_to = 0;
            cs_p1 = 1'b1; cs_p2 = 1'b1; edges = 0;
        end else begin
            edges++;
            if (soft_reset) begin
                m_phase = 0; m_elapsed = 0; m_quiet = 0; m_seen = 0;
            end else if (m_phase == 0) begin
                m_elapsed++;
                if (m_elapsed == POR) begin m_phase = 1; m_elapsed = 0; end
            end else if (m_phase == 1) begin
                m_elapsed++;
                if (m_elapsed == FDLY) begin m_phase = boot_mode ? 2 : 3; m_elapsed = 0; end
            end else if (m_phase == 2) begin
                seen_before = m_seen;
                m_elapsed++;
                if (cs_now) begin
                    m_quiet = (m_quiet < IDLE) ? m_quiet + 1 : IDLE;
                end else begin
                    m_quiet = 0;
                    m_seen  = 1;
                end
                quiet_done = seen_before && cs_now && (m_quiet == IDLE);
                if (loader_done || quiet_done) begin
                    m_phase = 3;
                end else if (m_elapsed == TMO) begin
                    m_phase = 3;
                    m_to    = 1;
                end
            end
            cs_p2 = cs_p1;
            cs_p1 = spi_cs;
        end
        m_valid = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edges, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_rst_n", 32'(rst_n), 32'(m_phase != 0));
            chk("model_fetch", 32'(fetch_en), 32'(m_phase == 3));
            chk("model_state", 32'(state), 32'(m_phase));
            chk("model_timeout", 32'(boot_timeout), 32'(m_to));
        end
    end

    task automatic go_edge(input int k);
        int guard = 0;
        while (edges < k && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        if (edges < k) begin
            chk("go_edge_timeout", 32'(edges), 32'(k));
        end
    endtask

    task automatic apply_reset(input logic mode);
        rst = 1'b1; spi_cs = 1'b1; loader_done = 1'b0; soft_reset = 1'b0;
        boot_mode = mode;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        // Mode 0: reset release, fetch after the release delay.
        apply_reset(1'b0);
        go_edge(15);
        chk("m0_rst_n_e15", 32'(rst_n), 32'd0);
        chk("m0_state_e15", 32'(state), 32'd0);
        go_edge(16);
        chk("m0_rst_n_e16", 32'(rst_n), 32'd1);
        chk("m0_state_e16", 32'(state), 32'd1);
        go_edge(19);
        chk("m0_fetch_e19", 32'(fetch_en), 32'd0);
        go_edge(20);
        chk("m0_fetch_e20", 32'(fetch_en), 32'd1);
        chk("m0_state_e20", 32'(state), 32'd3);
        chk("m0_timeout", 32'(boot_timeout), 32'd0);

        // Mode 1: done strobe sampled at edge 50.
        apply_reset(1'b1);
        go_edge(49);
        chk("m1_state_wait", 32'(state), 32'd2);
        loader_done = 1'b1;
        go_edge(50);
        loader_done = 1'b0;
        chk("m1_done_fetch", 32'(fetch_en), 32'd1);
        chk("m1_done_state", 32'(state), 32'd3);

        // Mode 1: CS low edges 30..40, then quiet.
        apply_reset(1'b1);
        go_edge(29);
        spi_cs = 1'b0;
        go_edge(40);
        spi_cs = 1'b1;
        go_edge(73);
        chk("idle_fetch_e73", 32'(fetch_en), 32'd0);
        go_edge(74);
        chk("idle_fetch_e74", 32'(fetch_en), 32'd1);
        chk("idle_timeout", 32'(boot_timeout), 32'd0);

        // Mode 1: timeout 256 edges after WAIT_LOAD entry at edge 20, then soft reset.
        apply_reset(1'b1);
        go_edge(275);
        chk("to_fetch_e275", 32'(fetch_en), 32'd0);
        go_edge(276);
        chk("to_fetch_e276", 32'(fetch_en), 32'd1);
        chk("to_flag_e276", 32'(boot_timeout), 32'd1);
        go_edge(280);
        soft_reset = 1'b1;
        go_edge(281);
        soft_reset = 1'b0;
        chk("soft_rst_n", 32'(rst_n), 32'd0);
        chk("soft_fetch", 32'(fetch_en), 32'd0);
        chk("soft_flag_kept", 32'(boot_timeout), 32'd1);
        go_edge(296);
        chk("soft_rst_n_e296", 32'(rst_n), 32'd0);
        go_edge(297);
        chk("soft_rst_n_e297", 32'(rst_n), 32'd1);
        apply_reset(1'b1);
        go_edge(16);
        chk("rerst_flag_clr", 32'(boot_timeout), 32'd0);
        chk("rerst_rst_n", 32'(rst_n), 32'd1);

        // Done strobe on the timeout edge wins.
        apply_reset(1'b1);
        go_edge(275);
        loader_done = 1'b1;
        go_edge(276);
        loader_done = 1'b0;
        chk("coinc_fetch", 32'(fetch_en), 32'd1);
        chk("coinc_flag", 32'(boot_timeout), 32'd0);

        // Soft reset beats done strobe.
        apply_reset(1'b1);
        go_edge(29);
        soft_reset = 1'b1;
        loader_done = 1'b1;
        go_edge(30);
        soft_reset = 1'b0;
        loader_done = 1'b0;
        chk("soft_done_state", 32'(state), 32'd0);
        chk("soft_done_rst_n", 32'(rst_n), 32'd0);

        // Hard reset in the middle of WAIT_LOAD.
        apply_reset(1'b1);
        go_edge(40);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rst_n", 32'(rst_n), 32'd0);
        chk("mid_rst_fetch", 32'(fetch_en), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        rst = 1'b0;

        // Randomized traffic, checked every cycle by the model.
        for (int run = 0; run < 12; run++) begin
            apply_reset(1'($urandom_range(0, 1)));
            hold = 0;
            for (int c = 0; c < 500; c++) begin
                if (hold == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        spi_cs = 1'b0;
                        hold = $urandom_range(1, 10);
                    end else begin
                        spi_cs = 1'b1;
                        hold = $urandom_range(1, 60);
                    end
                end
                hold--;
                loader_done = ($urandom_range(0, 149) == 0);
                soft_reset  = ($urandom_range(0, 399) == 0);
                @(negedge clk);
            end
            loader_done = 1'b0;
            soft_reset  = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
